// File: rtl/alu_execute_unit.sv
// rtl/alu_execute_unit.sv - execute stage: ALU control, ALU, branch-target adder, registered outputs
module alu_adder #(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              carry_in,
  output logic [DATA_W-1:0] sum
);
  assign sum = a + b + {{(DATA_W-1){1'b0}}, carry_in};
endmodule

module alu_control (
  input  logic [1:0]  alu_op,
  input  logic [10:0] opcode,
  output logic [3:0]  alu_func
);
  always_comb begin
    alu_func = 4'b0010;
    case (alu_op)
      2'b00: alu_func = 4'b0010;
      2'b01: alu_func = 4'b0111;
      default: begin
        case (opcode)
          11'b10001011000: alu_func = 4'b0010;
          11'b11001011000: alu_func = 4'b0110;
          11'b10001010000: alu_func = 4'b0000;
          11'b10101010000: alu_func = 4'b0001;
          default:         alu_func = 4'b0010;
        endcase
      end
    endcase
  end
endmodule

module alu_core #(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        alu_func,
  output logic [DATA_W-1:0] result,
  output logic              zero
);
  logic              is_sub;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W-1:0] sum;

  // One adder serves both add and subtract: A + ~B + 1 when subtracting.
  assign is_sub = (alu_func == 4'b0110);
  assign b_eff  = is_sub ? ~b : b;

  alu_adder #(.DATA_W(DATA_W)) u_adder (
    .a        (a),
    .b        (b_eff),
    .carry_in (is_sub),
    .sum      (sum)
  );

  always_comb begin
    result = '0;
    case (alu_func)
      4'b0000: result = a & b;
      4'b0001: result = a | b;
      4'b0010: result = sum;
      4'b0110: result = sum;
      4'b0111: result = b;
      4'b1100: result = ~(a | b);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
endmodule

module alu_execute_unit #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              register_reset,
  input  logic              register_write,
  input  logic [10:0]       opcode,
  input  logic [1:0]        alu_op,
  input  logic              alu_src,
  input  logic [DATA_W-1:0] read_data_1,
  input  logic [DATA_W-1:0] read_data_2,
  input  logic [DATA_W-1:0] extended_data,
  input  logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] alu_result,
  output logic              alu_zero,
  output logic [DATA_W-1:0] jump_address,
  output logic [3:0]        alu_func
);
  logic [DATA_W-1:0] operand_b;
  logic [DATA_W-1:0] result_comb;
  logic              zero_comb;
  logic [DATA_W-1:0] branch_offset;
  logic [DATA_W-1:0] target_comb;

  logic [DATA_W-1:0] alu_result_d, alu_result_q;
  logic              alu_zero_d, alu_zero_q;
  logic [DATA_W-1:0] jump_address_d, jump_address_q;

  alu_control u_alu_control (
    .alu_op   (alu_op),
    .opcode   (opcode),
    .alu_func (alu_func)
  );

  assign operand_b = alu_src ? extended_data : read_data_2;

  alu_core #(.DATA_W(DATA_W)) u_alu_core (
    .a        (read_data_1),
    .b        (operand_b),
    .alu_func (alu_func),
    .result   (result_comb),
    .zero     (zero_comb)
  );

  // Word offset to byte offset; the two top bits fall off.
  assign branch_offset = {extended_data[DATA_W-3:0], 2'b00};

  alu_adder #(.DATA_W(DATA_W)) u_branch_adder (
    .a        (pc),
    .b        (branch_offset),
    .carry_in (1'b0),
    .sum      (target_comb)
  );

  always_comb begin
    alu_result_d   = alu_result_q;
    alu_zero_d     = alu_zero_q;
    jump_address_d = jump_address_q;
    if (register_reset) begin
      alu_result_d   = '0;
      alu_zero_d     = 1'b0;
      jump_address_d = '0;
    end else if (register_write) begin
      alu_result_d   = result_comb;
      alu_zero_d     = zero_comb;
      jump_address_d = target_comb;
    end
  end

  always_ff @(posedge clk) begin
    alu_result_q   <= alu_result_d;
    alu_zero_q     <= alu_zero_d;
    jump_address_q <= jump_address_d;
  end

  assign alu_result   = alu_result_q;
  assign alu_zero     = alu_zero_q;
  assign jump_address = jump_address_q;
endmodule

// File: tb/tb_alu_execute_unit.sv
// tb/tb_alu_execute_unit.sv - table-driven scoreboard bench for alu_execute_unit
module tb_alu_execute_unit;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         register_reset;
  logic         register_write;
  logic [10:0]  opcode;
  logic [1:0]   alu_op;
  logic         alu_src;
  logic [W-1:0] read_data_1, read_data_2, extended_data, pc;
  logic [W-1:0] alu_result;
  logic         alu_zero;
  logic [W-1:0] jump_address;
  logic [3:0]   alu_func;

  always #5 clk = ~clk;

  alu_execute_unit #(.DATA_W(W)) dut (
    .clk            (clk),
    .register_reset (register_reset),
    .register_write (register_write),
    .opcode         (opcode),
    .alu_op         (alu_op),
    .alu_src        (alu_src),
    .read_data_1    (read_data_1),
    .read_data_2    (read_data_2),
    .extended_data  (extended_data),
    .pc             (pc),
    .alu_result     (alu_result),
    .alu_zero       (alu_zero),
    .jump_address   (jump_address),
    .alu_func       (alu_func)
  );

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [10:0]  opc;
    logic         src;
    logic [W-1:0] a, b, ext, pcv;
    logic [3:0]   func;
    logic [W-1:0] res;
    logic         zero;
    logic [W-1:0] jump;
  } vec_t;

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic         zero;
    logic [W-1:0] jump;
  } exp_t;

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;
  localparam logic [W-1:0] ONES  = {W{1'b1}};

  exp_t sb[$];
  exp_t held;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  // One clock of stimulus: drive at negedge, check alu_func, push expectation, compare after posedge.
  task automatic step(input vec_t v, input logic rst, input logic we);
    exp_t e, got;
    @(negedge clk);
    register_reset = rst;
    register_write = we;
    alu_op         = v.op;
    opcode         = v.opc;
    alu_src        = v.src;
    read_data_1    = v.a;
    read_data_2    = v.b;
    extended_data  = v.ext;
    pc             = v.pcv;
    #1;
    check({v.name, ".alu_func"}, W'(alu_func), W'(v.func));
    if (rst) begin
      e = '{v.name, '0, 1'b0, '0};
    end else if (we) begin
      e = '{v.name, v.res, v.zero, v.jump};
    end else begin
      e = held;
      e.name = v.name;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({got.name, ".alu_result"}, alu_result, got.res);
    check({got.name, ".alu_zero"}, W'(alu_zero), W'(got.zero));
    check({got.name, ".jump_address"}, jump_address, got.jump);
    held = got;
  endtask

  vec_t tbl[10];
  vec_t v;

  initial begin
    register_reset = 1'b1;
    register_write = 1'b1;
    opcode = '0; alu_op = '0; alu_src = 1'b0;
    read_data_1 = '0; read_data_2 = '0; extended_data = '0; pc = '0;
    held = '{"init", '0, 1'b0, '0};

    tbl[0] = '{"add_5_7",   2'b10, OPC_ADD, 1'b0, 64'd5,   64'd7,   64'd0, 64'd0, 4'b0010, 64'd12, 1'b0, 64'd0};
    tbl[1] = '{"sub_3_3",   2'b10, OPC_SUB, 1'b0, 64'd3,   64'd3,   64'd0, 64'd0, 4'b0110, 64'd0,  1'b1, 64'd0};
    tbl[2] = '{"sub_0_1",   2'b10, OPC_SUB, 1'b0, 64'd0,   64'd1,   64'd0, 64'd0, 4'b0110, ONES,   1'b0, 64'd0};
    tbl[3] = '{"and_f0_3c", 2'b10, OPC_AND, 1'b0, 64'hF0,  64'h3C,  64'd0, 64'd0, 4'b0000, 64'h30, 1'b0, 64'd0};
    tbl[4] = '{"orr_f0_0f", 2'b10, OPC_ORR, 1'b0, 64'hF0,  64'h0F,  64'd0, 64'd0, 4'b0001, 64'hFF, 1'b0, 64'd0};
    tbl[5] = '{"cbz",       2'b01, 11'h7FF, 1'b0, 64'h55,  64'd0,   64'hFFFF_FFFF_FFFF_FFFE, 64'h40, 4'b0111, 64'd0, 1'b1, 64'h38};
    tbl[6] = '{"ldaddr",    2'b00, 11'd0,   1'b1, 64'h100, 64'h999, 64'd8, 64'd0, 4'b0010, 64'h108, 1'b0, 64'h20};
    tbl[7] = '{"rtype_unk", 2'b11, 11'h123, 1'b0, 64'd1,   64'd2,   64'd0, 64'd0, 4'b0010, 64'd3,  1'b0, 64'd0};
    tbl[8] = '{"add_wrap",  2'b10, OPC_ADD, 1'b0, ONES,    64'd1,   64'd0, 64'd0, 4'b0010, 64'd0,  1'b1, 64'd0};
    tbl[9] = '{"shift_top", 2'b00, 11'd0,   1'b1, 64'd0,   64'd0,   64'hC000_0000_0000_0001, 64'd0, 4'b0010,
               64'hC000_0000_0000_0001, 1'b0, 64'd4};

    // Reset held two edges with nonzero inputs, then the first load of all-zero inputs.
    v = tbl[0]; v.name = "reset_edge1"; step(v, 1'b1, 1'b1);
    v.name = "reset_edge2";             step(v, 1'b1, 1'b1);
    v = '{"first_load", 2'b00, 11'd0, 1'b0, '0, '0, '0, '0, 4'b0010, '0, 1'b1, '0};
    step(v, 1'b0, 1'b1);

    for (int i = 0; i < 10; i++) step(tbl[i], 1'b0, 1'b1);

    // Load address, then hold while inputs change.
    step(tbl[6], 1'b0, 1'b1);
    v = tbl[0]; v.name = "hold1"; step(v, 1'b0, 1'b0);
    v = tbl[5]; v.name = "hold2"; step(v, 1'b0, 1'b0);

    // Reset wins over a simultaneous load.
    v = '{"rst_and_load", 2'b10, OPC_ADD, 1'b0, 64'd1, 64'd1, 64'd0, 64'd0, 4'b0010, 64'd2, 1'b0, 64'd0};
    step(v, 1'b1, 1'b1);
    v.name = "load_after_rst"; step(v, 1'b0, 1'b1);

    // Mid-stream reset after a nonzero jump target, then hold keeps zeros.
    step(tbl[5], 1'b0, 1'b1);
    v = tbl[9]; v.name = "midstream_rst"; step(v, 1'b1, 1'b0);
    v.name = "hold_after_rst"; step(v, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
